// File: rtl/hs_pkg.sv
// Shared definitions for the stream-to-handshake bridge: FSM state
// encodings, default sizing constants and a small parameter helper.
package hs_pkg;

  // Handshake sequencer states. The encodings are fixed so that waveforms
  // and any external debug taps agree on what each value means.
  typedef enum logic [1:0] {
    HS_IDLE = 2'd0,  // waiting for an upstream word
    HS_REQ  = 2'd1,  // sync high, waiting for the slave to raise ack
    HS_REL  = 2'd2   // sync low, waiting for the slave to drop ack
  } hs_state_e;

  localparam int HS_WIDTH_DEF   = 32;
  localparam int HS_DEPTH_DEF   = 4;
  localparam int HS_CNT_W_DEF   = 16;
  localparam int HS_TIMEOUT_DEF = 1024;

  // True when n is a non-zero power of two. The result FIFO depends on its
  // pointers wrapping naturally, so its depth has to be a power of two.
  function automatic bit hs_is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage : hs_pkg

// File: rtl/hs_result_fifo.sv
// Result FIFO for hs_stream_bridge: synchronous, first-word-fall-through.
// pop_data always shows the oldest entry; a push while full and a pop while
// empty are both ignored. Storing and removing in the same cycle leaves the
// occupancy unchanged and keeps the entries in order.
module hs_result_fifo
  import hs_pkg::*;
#(
  parameter int WIDTH = HS_WIDTH_DEF,
  parameter int DEPTH = HS_DEPTH_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Qualify the requests and compute the next pointers and occupancy.
  always_comb begin
    // NOTE: every variable gets a default first so no path through the
    // block leaves one unassigned; that is what keeps this free of latches.
    do_push  = push && (count_q != DEPTH_C);
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers are PTR_W bits wide, so the increment wraps modulo DEPTH.
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers, cleared by the synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments here, so every flop samples the values
    // from before the edge no matter what order the statements run in.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, written at the write pointer on an accepted push.
  always_ff @(posedge clock) begin
    // NOTE: storage is deliberately not reset. The pointers and count
    // decide which entries are valid, and leaving reset off the array lets
    // it map onto plain RAM or register-file cells.
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule : hs_result_fifo

// File: rtl/hs_stream_bridge.sv
// hs_stream_bridge: feeds a valid/ready word stream into a 4-phase sync/ack
// slave, one full handshake per word (sync up, ack up, sync down, ack down).
// Each slave result goes into an hs_result_fifo and leaves on a valid/ready
// output stream. Only one handshake is in flight at a time. A word is
// accepted only while the FIFO has room, so the result push never overflows.
//
// Optional build macro HS_STREAM_BRIDGE_TIMEOUT_EN: abort a request that gets
// no ack within TIMEOUT cycles and flag it on a sticky timeout_err output.
// Without the macro a request waits for ack indefinitely.
module hs_stream_bridge
  import hs_pkg::*;
#(
  parameter int WIDTH   = HS_WIDTH_DEF,
  parameter int DEPTH   = HS_DEPTH_DEF,
  parameter int CNT_W   = HS_CNT_W_DEF,
  parameter int TIMEOUT = HS_TIMEOUT_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             sync,
  input  logic             ack,
  output logic [WIDTH-1:0] data_to_slave,
  input  logic [WIDTH-1:0] data_from_slave,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic [CNT_W-1:0] txn_count
`ifdef HS_STREAM_BRIDGE_TIMEOUT_EN
  ,
  output logic             timeout_err
`endif
);

  localparam int FCNT_W = $clog2(DEPTH) + 1;
  localparam logic [FCNT_W-1:0] DEPTH_C = FCNT_W'(DEPTH);

  // Reject configurations the FIFO pointer arithmetic or the abort counter
  // cannot handle.
  if (!hs_is_pow2(DEPTH) || (DEPTH < 2) || (TIMEOUT < 1)) begin : g_param_check
    $error("hs_stream_bridge: DEPTH must be a power of 2 >= 2, TIMEOUT >= 1");
  end

  hs_state_e        state_q, state_d;
  logic             sync_q, sync_d;
  logic [WIDTH-1:0] dts_q, dts_d;
  logic [CNT_W-1:0] txn_q, txn_d;

  logic              accept;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FCNT_W-1:0] fifo_count;

`ifdef HS_STREAM_BRIDGE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             terr_q, terr_d;
  logic             tmo_hit;
`endif

  // Take a new word only when idle, when the FIFO has a slot reserved for
  // its result, and once the slave has let go of ack. The ack term matters
  // after a reset that cut a handshake short and left the slave still
  // holding ack high.
  assign in_ready = (state_q == HS_IDLE) && (fifo_count < DEPTH_C) && !ack;
  assign accept   = in_valid && in_ready;
  assign fifo_pop = out_valid && out_ready;

  // Handshake sequencer: next state, request word, counters and FIFO push.
  always_comb begin
    state_d   = state_q;
    sync_d    = sync_q;
    dts_d     = dts_q;
    txn_d     = txn_q;
    fifo_push = 1'b0;
`ifdef HS_STREAM_BRIDGE_TIMEOUT_EN
    terr_d  = terr_q;
    // The counter reads k-1 on the k-th cycle in REQ, so matching TIMEOUT-1
    // ends the request after exactly TIMEOUT cycles with sync high.
    tmo_hit = (tmo_q == TMO_W'(TIMEOUT - 1));
`endif
    case (state_q)
      HS_IDLE: begin
        // ack is ignored here apart from its part in in_ready.
        if (accept) begin
          dts_d   = in_data;
          sync_d  = 1'b1;
          state_d = HS_REQ;
        end
      end
      HS_REQ: begin
        // ack is checked first, so it wins when it arrives on the same
        // cycle as the timeout.
        if (ack) begin
          // A slot was reserved when the word was accepted, so full cannot
          // be seen here. The guard only protects the FIFO contents.
          fifo_push = !fifo_full;
          sync_d    = 1'b0;
          txn_d     = txn_q + CNT_W'(1);
          state_d   = HS_REL;
        end
`ifdef HS_STREAM_BRIDGE_TIMEOUT_EN
        else if (tmo_hit) begin
          // Abort: drop sync without pushing a result or counting the word.
          sync_d  = 1'b0;
          terr_d  = 1'b1;
          state_d = HS_REL;
        end
`endif
      end
      HS_REL: begin
        if (!ack) begin
          state_d = HS_IDLE;
        end
      end
      default: begin
        state_d = HS_IDLE;
        sync_d  = 1'b0;
      end
    endcase
`ifdef HS_STREAM_BRIDGE_TIMEOUT_EN
    // The counter runs only while the request stays in REQ. It clears as
    // soon as the sequencer leaves REQ, whether on ack or on abort.
    tmo_d = ((state_q == HS_REQ) && (state_d == HS_REQ)) ? (tmo_q + TMO_W'(1)) : '0;
`endif
  end

  // Sequencer registers. Reset drops sync on the reset edge, even in the
  // middle of a handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= HS_IDLE;
      sync_q  <= 1'b0;
      dts_q   <= '0;
      txn_q   <= '0;
`ifdef HS_STREAM_BRIDGE_TIMEOUT_EN
      tmo_q   <= '0;
      terr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      dts_q   <= dts_d;
      txn_q   <= txn_d;
`ifdef HS_STREAM_BRIDGE_TIMEOUT_EN
      tmo_q   <= tmo_d;
      terr_q  <= terr_d;
`endif
    end
  end

  // Result buffer. Reset clears it, so pending results are discarded.
  hs_result_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (data_from_slave),
    .pop       (fifo_pop),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid     = !fifo_empty;
  assign sync          = sync_q;
  assign data_to_slave = dts_q;
  assign busy          = (state_q != HS_IDLE);
  assign txn_count     = txn_q;
`ifdef HS_STREAM_BRIDGE_TIMEOUT_EN
  assign timeout_err   = terr_q;
`endif

endmodule : hs_stream_bridge

// File: tb/tb_hs_stream_bridge.sv
// Self-checking bench for hs_stream_bridge. A background driver feeds words
// from send_q. Each accepted word pushes its expected result f(x) = x + 1
// into a scoreboard queue, and a monitor pops and compares whenever the
// bridge hands a result downstream. The slave model acks after a
// programmable delay. Directed sections cover latency, back-pressure,
// simultaneous push/pop, reset mid-handshake, counter wrap (CNT_W = 8) and,
// with HS_STREAM_BRIDGE_TIMEOUT_EN, the request abort.
module tb_hs_stream_bridge;

  localparam int WIDTH   = 32;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 8;
  localparam int BUDGET  = 20000;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             sync;
  logic             ack = 1'b0;
  logic [WIDTH-1:0] data_to_slave;
  logic [WIDTH-1:0] data_from_slave;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;
  logic [CNT_W-1:0] txn_count;
`ifdef HS_STREAM_BRIDGE_TIMEOUT_EN
  logic             timeout_err;
`endif

  always #5 clock = ~clock;

  hs_stream_bridge #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .sync            (sync),
    .ack             (ack),
    .data_to_slave   (data_to_slave),
    .data_from_slave (data_from_slave),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .busy            (busy),
    .txn_count       (txn_count)
`ifdef HS_STREAM_BRIDGE_TIMEOUT_EN
    ,
    .timeout_err     (timeout_err)
`endif
  );

  // ---------------- bookkeeping ----------------
  int checks_total  = 0;
  int checks_passed = 0;
  int model_txn     = 0;  // handshakes completed since the last reset

  logic [WIDTH-1:0] send_q[$];
  logic [WIDTH-1:0] exp_q[$];

  bit mute      = 1'b0;  // slave never acks
  bit ack_force = 1'b0;  // slave holds ack high regardless of sync
  bit rr_en     = 1'b0;  // randomise out_ready and ack delay
  bit gap_en    = 1'b0;  // random bubbles on in_valid
  int ack_delay = 0;
  int dly_cnt   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks_total++;
    if (act === req) checks_passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  task automatic fail_timeout(input string name, input int waited);
    checks_total++;
    $display("FAIL %s: condition not reached after %0d cycles, required within %0d", name, waited, BUDGET);
  endtask

  function automatic logic [63:0] exp_txn();
    return 64'(model_txn % (1 << CNT_W));
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // ---------------- slave model: result = request + 1 ----------------
  assign data_from_slave = data_to_slave + 32'd1;

  always @(posedge clock) begin
    if (ack_force) begin
      ack     <= 1'b1;
      dly_cnt <= 0;
    end else if (sync && !ack && !mute) begin
      if (dly_cnt >= ack_delay) begin
        ack     <= 1'b1;
        dly_cnt <= 0;
      end else begin
        dly_cnt <= dly_cnt + 1;
      end
    end else if (!sync) begin
      ack     <= 1'b0;
      dly_cnt <= 0;
    end
  end

  // ---------------- driver: feeds send_q, predicts results ----------------
  initial begin
    bit fire;
    logic [WIDTH-1:0] w;
    in_valid = 1'b0;
    in_data  = '0;
    forever begin
      @(negedge clock);
      fire = in_valid && in_ready && !reset;
      @(posedge clock);
      #1;
      if (fire && send_q.size() > 0) begin
        w = send_q.pop_front();
        exp_q.push_back(w + 32'd1);
      end
      if (send_q.size() > 0 && !(gap_en && $urandom_range(3) == 0)) begin
        in_valid = 1'b1;
        in_data  = send_q[0];
      end else begin
        in_valid = 1'b0;
        in_data  = $urandom;
      end
    end
  end

  // ---------------- randomiser for out_ready / ack delay ----------------
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (rr_en) begin
        out_ready = ($urandom_range(3) != 0);
        ack_delay = $urandom_range(3);
      end
    end
  end

  // ---------------- monitor: compares every delivered result ----------------
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks_total++;
        $display("FAIL sb_unexpected: got 0x%0h, required no output", out_data);
      end else begin
        check("sb_data", 64'(out_data), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation reached %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- wait helpers ----------------
  task automatic wait_sync(input string name);
    int n = 0;
    while (!sync && n < BUDGET) begin step(); n++; end
    if (!sync) fail_timeout(name, n);
  endtask

  task automatic wait_not_busy(input string name);
    int n = 0;
    while (busy && n < BUDGET) begin step(); n++; end
    if (busy) fail_timeout(name, n);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((send_q.size() != 0 || exp_q.size() != 0 || busy) && n < BUDGET) begin
      step();
      n++;
    end
    if (n >= BUDGET) fail_timeout(name, n);
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    int n;
    logic ov_before;
    reset     = 1'b1;
    out_ready = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_sync", 64'(sync), 64'(0));
    check("rst_data_to_slave", 64'(data_to_slave), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_txn_count", 64'(txn_count), 64'(0));
    reset = 1'b0;
    step();
    check("rst_in_ready", 64'(in_ready), 64'(1));

    // 1: single word 0x10, slave acks one cycle after sync
    ack_delay = 0;
    send_q.push_back(32'h10);
    wait_sync("t1_accept");
    n = 0;
    ov_before = 1'b0;
    while (sync && n < 50) begin ov_before = out_valid; n++; step(); end
    check("t1_sync_cycles", 64'(n), 64'(2));
    check("t1_out_valid_before_push", 64'(ov_before), 64'(0));
    check("t1_out_valid", 64'(out_valid), 64'(1));
    check("t1_out_data", 64'(out_data), 64'h11);
    model_txn = 1;
    check("t1_txn_count", 64'(txn_count), exp_txn());
    check("t1_busy_in_rel", 64'(busy), 64'(1));
    wait_not_busy("t1_idle");
    check("t1_in_ready_idle", 64'(in_ready), 64'(1));
    out_ready = 1'b1;
    wait_drain("t1_drain");
    out_ready = 1'b0;
    check("t1_drained", 64'(out_valid), 64'(0));

    // 2: back-pressure, five words into a four-entry FIFO
    for (int i = 1; i <= 5; i++) send_q.push_back(32'(i));
    n = 0;
    while (!(send_q.size() == 1 && !busy && out_valid) && n < BUDGET) begin step(); n++; end
    if (n >= BUDGET) fail_timeout("t2_fill", n);
    repeat (3) step();
    check("t2_in_ready_full", 64'(in_ready), 64'(0));
    check("t2_pending", 64'(send_q.size()), 64'(1));
    check("t2_head", 64'(out_data), 64'h2);
    check("t2_txn_count", 64'(txn_count), 64'(model_txn + 4));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n = 0;
    while ((send_q.size() != 0 || busy) && n < BUDGET) begin step(); n++; end
    if (n >= BUDGET) fail_timeout("t2_accept5", n);
    check("t2_accepted_5", 64'(send_q.size()), 64'(0));
    check("t2_head_after_pop", 64'(out_data), 64'h3);
    out_ready = 1'b1;
    wait_drain("t2_drain");
    out_ready = 1'b0;
    model_txn += 5;
    check("t2_txn_after", 64'(txn_count), exp_txn());

    // 3: push and pop on the same edge with one entry held
    send_q.push_back(32'h9);
    n = 0;
    while (!(out_valid && !busy) && n < BUDGET) begin step(); n++; end
    if (n >= BUDGET) fail_timeout("t3_first", n);
    check("t3_head_A", 64'(out_data), 64'hA);
    send_q.push_back(32'hA);
    wait_sync("t3_accept");
    step();
    check("t3_ack_aligned", 64'(ack), 64'(1));
    check("t3_head_pre", 64'(out_data), 64'hA);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t3_valid_kept", 64'(out_valid), 64'(1));
    check("t3_head_B", 64'(out_data), 64'hB);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t3_count_was_1", 64'(out_valid), 64'(0));
    wait_not_busy("t3_idle");
    model_txn += 2;
    check("t3_txn_count", 64'(txn_count), exp_txn());

    // 4: reset during REQ while the slave keeps ack high afterwards
    mute = 1'b1;
    send_q.push_back(32'h77);
    wait_sync("t4_accept");
    step();
    check("t4_pre_sync", 64'(sync), 64'(1));
    check("t4_pre_ack", 64'(ack), 64'(0));
    reset     = 1'b1;
    ack_force = 1'b1;
    send_q.delete();
    step();
    exp_q.delete();
    reset = 1'b0;
    model_txn = 0;
    check("t4_sync_dropped", 64'(sync), 64'(0));
    check("t4_out_valid", 64'(out_valid), 64'(0));
    check("t4_busy", 64'(busy), 64'(0));
    check("t4_txn_count", 64'(txn_count), 64'(0));
    for (int i = 0; i < 3; i++) begin
      check("t4_in_ready_blocked", 64'(in_ready), 64'(0));
      step();
    end
    ack_force = 1'b0;
    mute      = 1'b0;
    step();
    check("t4_in_ready_released", 64'(in_ready), 64'(1));

    // Random traffic: data, ack delay, out_ready and input bubbles
    rr_en  = 1'b1;
    gap_en = 1'b1;
    for (int i = 0; i < 200; i++) send_q.push_back($urandom);
    model_txn += 200;
    wait_drain("rnd_drain");
    rr_en     = 1'b0;
    gap_en    = 1'b0;
    ack_delay = 0;
    out_ready = 1'b1;
    wait_drain("rnd_settle");
    check("rnd_txn_count", 64'(txn_count), exp_txn());
    check("rnd_empty", 64'(out_valid), 64'(0));

    // 6: counter wrap at 2^CNT_W
    n = (1 << CNT_W) - 1 - (model_txn % (1 << CNT_W));
    for (int i = 0; i < n; i++) send_q.push_back($urandom);
    model_txn += n;
    wait_drain("wrap_fill");
    check("wrap_max", 64'(txn_count), 64'((1 << CNT_W) - 1));
    send_q.push_back(32'hCAFE);
    model_txn++;
    wait_drain("wrap_last");
    check("wrap_zero", 64'(txn_count), 64'(0));

`ifdef HS_STREAM_BRIDGE_TIMEOUT_EN
    // 5: slave never acks, request aborts after TIMEOUT cycles in REQ
    check("to_err_clear", 64'(timeout_err), 64'(0));
    mute = 1'b1;
    send_q.push_back(32'h55);
    wait_sync("to_accept");
    n = 0;
    while (sync && n < 50) begin n++; step(); end
    exp_q.delete();
    check("to_sync_cycles", 64'(n), 64'(TIMEOUT));
    check("to_err_set", 64'(timeout_err), 64'(1));
    check("to_out_valid", 64'(out_valid), 64'(0));
    check("to_txn_unchanged", 64'(txn_count), exp_txn());
    mute = 1'b0;
    wait_not_busy("to_idle");
    check("to_err_sticky", 64'(timeout_err), 64'(1));
    send_q.push_back(32'h60);
    model_txn++;
    wait_drain("to_recover");
    check("to_txn_after", 64'(txn_count), exp_txn());
    check("to_err_still_set", 64'(timeout_err), 64'(1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_txn = 0;
    check("to_err_reset", 64'(timeout_err), 64'(0));
`endif

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule : tb_hs_stream_bridge
